// File: rtl/img_pkg.sv
// img_pkg: shared image/window constants, read FSM states and row-major window lane indexing
package img_pkg;
  localparam int IMG_W = 640;
  localparam int PIX_W = 8;
  localparam int KERNEL = 3;
  localparam int NUM_ROWS = 4;
  localparam int WIN_W = KERNEL * KERNEL * PIX_W;
  typedef enum logic [1:0] {IDLE, READ, DONE} rd_state_e;
  function automatic int lane_idx(int r, int c);
    return (KERNEL * KERNEL - 1) - (r * KERNEL + c);
  endfunction
endpackage

// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel stream in (pix_in/valid/ready) and 3x3 window out (win_out/valid/ready)
interface window_gen_3x3_if #(parameter int PIX_W = 8);
  logic [PIX_W-1:0] pix_in;
  logic pix_in_valid;
  logic pix_in_ready;
  logic [9*PIX_W-1:0] win_out;
  logic win_valid;
  logic win_ready;
  modport master(output pix_in, pix_in_valid, win_ready, input pix_in_ready, win_out, win_valid);
  modport slave(input pix_in, pix_in_valid, win_ready, output pix_in_ready, win_out, win_valid);
endinterface

// File: rtl/row_mem.sv
// row_mem: one image row (clk, rst, write we/wa/wd, read-enable re at column ra -> registered rd = cols ra..ra+2)
module row_mem #(
  parameter int IMG_W = 640,
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] wa,
  input  logic [PIX_W-1:0]         wd,
  input  logic                     re,
  input  logic [$clog2(IMG_W)-1:0] ra,
  output logic [PIX_W-1:0]         rd [3]
);
  localparam int CW = $clog2(IMG_W);
  logic [PIX_W-1:0] mem [IMG_W];
  logic [PIX_W-1:0] rd_q [3];
  logic [PIX_W-1:0] rd_d [3];
  always_ff @(posedge clk) if (we) mem[wa] <= wd;
  always_comb begin
    for (int i = 0; i < 3; i++) rd_d[i] = re ? mem[ra + CW'(i)] : rd_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '{default: '0};
    else rd_q <= rd_d;
  end
  assign rd = rd_q;
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream -> valid-only 3x3 windows via 4 rotating rows (clk, rst, bus: slave side of window_gen_3x3_if)
module window_gen_3x3 #(
  parameter int IMG_W = img_pkg::IMG_W,
  parameter int PIX_W = img_pkg::PIX_W
) (
  input logic            clk,
  input logic            rst,
  window_gen_3x3_if.slave bus
);
  import img_pkg::KERNEL;
  import img_pkg::NUM_ROWS;
  import img_pkg::rd_state_e;
  import img_pkg::IDLE;
  import img_pkg::READ;
  import img_pkg::DONE;
  import img_pkg::lane_idx;
  localparam int CW = $clog2(IMG_W);
  localparam int FW = $clog2(4 * IMG_W + 1);
  localparam logic [FW-1:0] ROW_FILL = FW'(IMG_W);
  localparam logic [FW-1:0] RD_MIN = FW'(3 * IMG_W);
  localparam logic [FW-1:0] CAP = FW'(4 * IMG_W);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 3);
  localparam logic [CW-1:0] END_COL = CW'(IMG_W - 1);
  rd_state_e state_q, state_d;
  logic [CW-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d, win_row_q, win_row_d;
  logic [FW-1:0] fill_q, fill_d;
  logic win_valid_q, win_valid_d;
  logic wr_en, adv, row_done;
  logic [PIX_W-1:0] row_pix [NUM_ROWS][KERNEL];
  logic [9*PIX_W-1:0] win_out;
  assign bus.pix_in_ready = fill_q < CAP;
  assign wr_en = bus.pix_in_valid && bus.pix_in_ready;
  assign adv = (state_q == READ) && (!win_valid_q || bus.win_ready);
  assign row_done = adv && (rd_col_q == LAST_COL);
  always_comb begin
    wr_col_d = wr_en ? ((wr_col_q == END_COL) ? '0 : wr_col_q + CW'(1)) : wr_col_q;
    wr_row_d = wr_row_q + 2'(wr_en && (wr_col_q == END_COL));
    rd_col_d = adv ? (row_done ? '0 : rd_col_q + CW'(1)) : rd_col_q;
    rd_row_d = rd_row_q + 2'(row_done);
    // the row selection travels with the captured data so win_out stays put after rd_row advances
    win_row_d = adv ? rd_row_q : win_row_q;
    fill_d = fill_q + FW'(wr_en) - (row_done ? ROW_FILL : '0);
    win_valid_d = adv || (win_valid_q && !bus.win_ready);
    state_d = (state_q == IDLE && fill_q >= RD_MIN) ? READ :
              row_done ? DONE :
              (state_q == DONE && win_valid_q && bus.win_ready) ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_col_q <= '0;
      rd_col_q <= '0;
      wr_row_q <= '0;
      rd_row_q <= '0;
      win_row_q <= '0;
      fill_q <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_col_q <= wr_col_d;
      rd_col_q <= rd_col_d;
      wr_row_q <= wr_row_d;
      rd_row_q <= rd_row_d;
      win_row_q <= win_row_d;
      fill_q <= fill_d;
      win_valid_q <= win_valid_d;
    end
  end
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    row_mem #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_row (
      .clk(clk),
      .rst(rst),
      .we(wr_en && (wr_row_q == 2'(g))),
      .wa(wr_col_q),
      .wd(bus.pix_in),
      .re(adv),
      .ra(rd_col_q),
      .rd(row_pix[g])
    );
  end
  always_comb begin
    win_out = '0;
    for (int r = 0; r < KERNEL; r++)
      for (int c = 0; c < KERNEL; c++)
        win_out[lane_idx(r, c)*PIX_W +: PIX_W] = row_pix[win_row_q + 2'(r)][c];
  end
  assign bus.win_out = win_out;
  assign bus.win_valid = win_valid_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: scoreboard bench for window_gen_3x3 with IMG_W=8, pixel = row*16 + col
module tb_window_gen_3x3;
  localparam int W = 8;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  window_gen_3x3_if #(.PIX_W(PW)) bus();
  window_gen_3x3 #(.IMG_W(W), .PIX_W(PW)) dut(.clk(clk), .rst(rst), .bus(bus));
  int total = 0;
  int bad = 0;
  logic [71:0] q[$];
  int n_pix = 0, n_acc = 0, fm = 0, n_target = 0, n_simul = 0;
  logic [71:0] first_w = '0, last_w = '0, row3_w = '0;
  function automatic logic [7:0] pix(int n);
    return 8'((n / W) * 16 + n % W);
  endfunction
  function automatic logic [71:0] win(int r, int c);
    logic [71:0] w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int cc = 0; cc < 3; cc++) w = {w[63:0], pix((r + rr) * W + c + cc)};
    return w;
  endfunction
  task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    logic acc_p, acc_w, hold, pre_v;
    logic [71:0] pre_w, got;
    int pre_cap, post_cap;
    bus.pix_in = pix(n_pix);
    bus.pix_in_valid = !rst && (n_pix < n_target);
    #1;
    acc_p = bus.pix_in_valid && bus.pix_in_ready && !rst;
    acc_w = bus.win_valid && bus.win_ready && !rst;
    pre_v = bus.win_valid;
    pre_w = bus.win_out;
    hold = pre_v && !bus.win_ready && !rst;
    pre_cap = n_acc + int'(pre_v);
    if (acc_w) begin
      got = bus.win_out;
      if (q.size() == 0) chk("extra_win", got, '0);
      else chk("win", got, q.pop_front());
      if (n_acc == 0) first_w = got;
      if (n_acc == 18) row3_w = got;
      last_w = got;
      n_acc++;
    end
    if (acc_p) begin
      fm++;
      if ((n_pix % W) == W - 1 && (n_pix / W) >= 2)
        for (int c = 0; c < W - 2; c++) q.push_back(win(n_pix / W - 2, c));
      n_pix++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      n_pix = 0;
      n_acc = 0;
      fm = 0;
      first_w = '0;
      chk("rst_valid", 72'(bus.win_valid), 72'(0));
      chk("rst_ready", 72'(bus.pix_in_ready), 72'(1));
      chk("rst_winout", bus.win_out, '0);
      chk("rst_fill", 72'(dut.fill_q), 72'(0));
    end else begin
      post_cap = n_acc + int'(bus.win_valid);
      if (post_cap / (W - 2) != pre_cap / (W - 2)) begin
        fm -= W;
        if (acc_p) n_simul++;
      end
      if (hold) begin
        chk("hold_valid", 72'(bus.win_valid), 72'(1));
        chk("hold_win", bus.win_out, pre_w);
      end
      chk("fill", 72'(dut.fill_q), 72'(fm));
      chk("ready", 72'(bus.pix_in_ready), 72'(fm < 4 * W));
    end
  endtask
  task automatic drain(string tag, int lim);
    int k = 0;
    while ((n_pix < n_target || q.size() > 0 || bus.win_valid) && k < lim) begin
      cycle();
      k++;
    end
    chk(tag, 72'(k < lim), 72'(1));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask
  initial begin
    bus.pix_in = '0;
    bus.pix_in_valid = 1'b0;
    bus.win_ready = 1'b1;
    do_reset();
    do_reset();
    n_target = 24;
    drain("fill_timeout", 100);
    chk("first_win", first_w, 72'h000102101112202122);
    chk("last_win", last_w, 72'h050607151617252627);
    chk("fill16", 72'(dut.fill_q), 72'(16));
    n_target = 32;
    for (int k = 0; k < 50 && !bus.win_valid; k++) cycle();
    chk("bp_start", 72'(bus.win_valid), 72'(1));
    cycle();
    bus.win_ready = 1'b0;
    repeat (5) cycle();
    bus.win_ready = 1'b1;
    drain("bp_timeout", 100);
    chk("bp_cnt", 72'(n_acc), 72'(12));
    do_reset();
    bus.win_ready = 1'b0;
    n_target = 40;
    for (int k = 0; k < 80 && n_pix < 32; k++) cycle();
    chk("full_cnt", 72'(n_pix), 72'(32));
    chk("full_ready", 72'(bus.pix_in_ready), 72'(0));
    repeat (5) cycle();
    chk("full_hold", 72'(n_pix), 72'(32));
    bus.win_ready = 1'b1;
    for (int k = 0; k < 40 && n_pix < 33; k++) cycle();
    chk("px33", 72'(n_pix), 72'(33));
    drain("full_timeout", 200);
    chk("full_wins", 72'(n_acc), 72'(18));
    do_reset();
    n_simul = 0;
    n_target = 48;
    drain("wrap_timeout", 300);
    chk("wrap_cnt", 72'(n_acc), 72'(24));
    chk("wrap_row3", row3_w, 72'h303132404142505152);
    chk("simul_seen", 72'(n_simul > 0), 72'(1));
    do_reset();
    n_target = 24;
    for (int k = 0; k < 100 && n_acc < 2; k++) cycle();
    chk("mid_read", 72'(n_acc), 72'(2));
    do_reset();
    n_target = 24;
    drain("rst_timeout", 100);
    chk("rst_first", first_w, 72'h000102101112202122);
    chk("rst_cnt", 72'(n_acc), 72'(6));
    chk("queue_empty", 72'(q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
